// File: rtl/uart_word_pkg.sv
// Shared frame format and defaults for the single-wire 32-bit word link.
package uart_word_pkg;

  localparam int DATA_W       = 32;
  localparam int CLKS_PER_BIT = 4;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

endpackage

// File: rtl/uart_word_link_if.sv
// Host-side bundle of the loopback link: word request, status, and a wired-AND line tap.
interface uart_word_link_if #(
  parameter int DATA_W = uart_word_pkg::DATA_W
);

  logic              startBit;
  logic [DATA_W-1:0] data_in;
  logic              ext_rx;
  logic              busy;
  logic              tx;
  logic [DATA_W-1:0] data_out;
  logic              dataReady;

  modport master (
    output startBit, data_in, ext_rx,
    input  busy, tx, data_out, dataReady
  );

  modport slave (
    input  startBit, data_in, ext_rx,
    output busy, tx, data_out, dataReady
  );

endinterface

// File: rtl/bit_timer.sv
// Per-bit down-counter; flags the mid-bit and last cycle of each serial bit while running.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic mid,
  output logic done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LOAD    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_CNT = CW'(CLKS_PER_BIT / 2);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = run && (cnt_q == '0);
  assign mid  = run && (cnt_q == MID_CNT);

  // Held at LOAD while stopped so the first running cycle starts a full bit.
  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (!run || done) begin
      cnt_d = LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/receiver.sv
// Recovers one word per frame from the serial line, sampling each bit at mid-bit.
//   state | meaning
//   IDLE  | waiting for a synchronised low
//   START | confirming the start bit at mid-bit, glitches fall back to IDLE
//   DATA  | sampling data bits, LSB first
//   STOP  | checking the stop level; good frames load data_out and pulse dataReady
module receiver
  import uart_word_pkg::*;
#(
  parameter int DATA_W       = uart_word_pkg::DATA_W,
  parameter int CLKS_PER_BIT = uart_word_pkg::CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              dataReady
);

  localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic              rx_s1_q, rx_s2_q;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rdy_q, rdy_d;
  logic              bit_mid, bit_done;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (state_q != IDLE),
    .mid   (bit_mid),
    .done  (bit_done)
  );

  assign data_out  = dout_q;
  assign dataReady = rdy_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    dout_d    = dout_q;
    rdy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_s2_q == START_LVL) begin
          state_d = START;
        end
      end
      START: begin
        if (bit_mid && (rx_s2_q != START_LVL)) begin
          state_d = IDLE;
        end else if (bit_done) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_mid) begin
          shreg_d = {rx_s2_q, shreg_q[DATA_W-1:1]};
        end
        if (bit_done) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        // Leave at mid-bit so a back-to-back start edge is not missed.
        if (bit_mid) begin
          state_d = IDLE;
          if (rx_s2_q == STOP_LVL) begin
            dout_d = shreg_q;
            rdy_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rx_s1_q   <= STOP_LVL;
      rx_s2_q   <= STOP_LVL;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      dout_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      dout_q    <= dout_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: rtl/transmitter.sv
// Serialises one word per frame: start bit, DATA_W bits LSB first, stop bit.
//   state | meaning
//   IDLE  | line high, waiting for startBit
//   START | driving the start bit
//   DATA  | shifting out data bits, LSB first
//   STOP  | driving the stop bit, busy drops at its end
module transmitter
  import uart_word_pkg::*;
#(
  parameter int DATA_W       = uart_word_pkg::DATA_W,
  parameter int CLKS_PER_BIT = uart_word_pkg::CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startBit,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              tx
);

  localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bit_done;
  logic              unused_mid;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (state_q != IDLE),
    .mid   (unused_mid),
    .done  (bit_done)
  );

  assign tx   = tx_q;
  assign busy = busy_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (startBit) begin
          state_d   = START;
          shreg_d   = data_in;
          bit_cnt_d = '0;
          tx_d      = START_LVL;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = STOP_LVL;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= STOP_LVL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: rtl/uart_word_link.sv
// Loopback wrapper: tx feeds rx through a wired-AND with an external line tap.
module uart_word_link #(
  parameter int DATA_W       = uart_word_pkg::DATA_W,
  parameter int CLKS_PER_BIT = uart_word_pkg::CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             reset,
  uart_word_link_if.slave  link
);

  logic tx_line;
  logic rx_line;

  // ext_rx idles high, so it only disturbs the line when pulled low.
  assign rx_line = tx_line & link.ext_rx;
  assign link.tx = tx_line;

  transmitter #(.DATA_W(DATA_W), .CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .reset    (reset),
    .startBit (link.startBit),
    .data_in  (link.data_in),
    .busy     (link.busy),
    .tx       (tx_line)
  );

  receiver #(.DATA_W(DATA_W), .CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx_line),
    .data_out  (link.data_out),
    .dataReady (link.dataReady)
  );

endmodule

// File: tb/tb_uart_word_link.sv
// Self-checking bench for the loopback word link against a frame-level model.
module tb_uart_word_link;
  import uart_word_pkg::*;

  localparam int W      = DATA_W;
  localparam int CPB    = CLKS_PER_BIT;
  localparam int FRAME  = (W + 2) * CPB;
  localparam int MAXLAT = ((2 * W + 3) * CPB) / 2 + 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_word_link_if lnk ();

  uart_word_link dut (
    .clk   (clk),
    .reset (reset),
    .link  (lnk)
  );

  typedef struct {
    logic [W-1:0] word;
    int           k;
  } exp_t;

  int           passed = 0;
  int           total = 0;
  int           cyc = 0;
  int           last_k = -1000000;
  logic [W-1:0] last_word = '0;
  exp_t         pend[$];
  logic [W-1:0] exp_dout = '0;
  int           last_pulse = -1;
  int           pulse_count = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic logic model_busy(input int c);
    return (c >= last_k + 1) && (c <= last_k + FRAME);
  endfunction

  function automatic logic model_tx(input int c);
    int idx;
    if (!model_busy(c)) return 1'b1;
    idx = (c - last_k - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= W) return last_word[idx-1];
    return 1'b1;
  endfunction

  // Acceptance model: evaluated on each rising edge for the cycle that is ending.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      last_k   = -1000000;
      pend.delete();
      exp_dout = '0;
    end else if (!model_busy(cyc) && lnk.startBit) begin
      exp_t e;
      last_k    = cyc;
      last_word = lnk.data_in;
      e.word    = lnk.data_in;
      e.k       = cyc;
      pend.push_back(e);
    end
    cyc++;
  end

  // Cycle-by-cycle compare, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("rst_tx", lnk.tx, 1);
      chk("rst_busy", lnk.busy, 0);
      chk("rst_ready", lnk.dataReady, 0);
      chk("rst_dout", lnk.data_out, 0);
    end else begin
      chk("tx", lnk.tx, model_tx(cyc));
      chk("busy", lnk.busy, model_busy(cyc));
      if (lnk.dataReady) begin
        pulse_count++;
        last_pulse = cyc;
        if (pend.size() == 0) begin
          total++;
          $display("FAIL unexpected_pulse: got dataReady=1 with data_out %h, required no pulse, cycle %0d",
                   lnk.data_out, cyc);
        end else begin
          chk("pulse_value", lnk.data_out, pend[0].word);
          total++;
          if (cyc > pend[0].k + 1 + (W + 1) * CPB && cyc <= pend[0].k + MAXLAT) passed++;
          else $display("FAIL pulse_latency: got %0d cycles after acceptance, required %0d..%0d",
                        cyc - pend[0].k, 2 + (W + 1) * CPB, MAXLAT);
          exp_dout = pend[0].word;
          void'(pend.pop_front());
        end
      end else if (pend.size() != 0 && cyc > pend[0].k + MAXLAT) begin
        total++;
        $display("FAIL missing_pulse: got no dataReady for word %h, required by cycle %0d",
                 pend[0].word, pend[0].k + MAXLAT);
        void'(pend.pop_front());
      end
      chk("data_out", lnk.data_out, exp_dout);
    end
  end

  task automatic send(input logic [W-1:0] w, input bit hold);
    int k0;
    int g;
    k0 = last_k;
    g  = 0;
    @(posedge clk); #2;
    lnk.startBit = 1'b1;
    lnk.data_in  = w;
    while (last_k == k0 && g < 400) begin
      @(posedge clk); #2;
      g++;
    end
    if (g >= 400) begin
      total++;
      $display("FAIL accept_timeout: got no acceptance in %0d cycles, required one", g);
    end
    if (!hold) lnk.startBit = 1'b0;
    lnk.data_in = $urandom;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((model_busy(cyc) || pend.size() != 0) && g < 2000) begin
      @(posedge clk); #2;
      g++;
    end
    if (g >= 2000) begin
      total++;
      $display("FAIL idle_timeout: got still busy after %0d cycles, required idle", g);
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic at_cycle(input int c);
    int g;
    g = 0;
    @(negedge clk);
    while (cyc < c && g < 1000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic drive_line_bit(input logic b);
    lnk.ext_rx = b;
    repeat (CPB) @(posedge clk);
    #2;
  endtask

  initial begin
    int           k1;
    int           g;
    int           pc;
    logic [W-1:0] w;
    logic [W-1:0] junk;

    lnk.startBit = 1'b0;
    lnk.data_in  = '0;
    lnk.ext_rx   = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("reset_dout", lnk.data_out, 0);
    chk("reset_tx", lnk.tx, 1);

    // All ones: busy window edges and latency bound.
    send(32'hFFFF_FFFF, 1'b0);
    k1 = last_k;
    at_cycle(k1 + FRAME);
    chk("busy_last_cycle", lnk.busy, 1);
    at_cycle(k1 + FRAME + 1);
    chk("busy_dropped", lnk.busy, 0);
    wait_idle();
    chk("ones_dout", lnk.data_out, 32'hFFFF_FFFF);
    chk("ones_latency_ok", W'(last_pulse > k1 && last_pulse <= k1 + 138), 1);

    // All zeros.
    send(32'h0000_0000, 1'b0);
    wait_idle();
    chk("zeros_dout", lnk.data_out, 32'h0000_0000);

    // Bit positions on the wire.
    send(32'hA5A5_3C01, 1'b0);
    k1 = last_k;
    at_cycle(k1 + 1);
    chk("start_bit_low", lnk.tx, 0);
    at_cycle(k1 + 1 + CPB + 1);
    chk("first_data_bit", lnk.tx, 1);
    at_cycle(k1 + 1 + W * CPB + 1);
    chk("last_data_bit", lnk.tx, 1);
    at_cycle(k1 + 1 + (W + 1) * CPB + 1);
    chk("stop_bit", lnk.tx, 1);
    wait_idle();
    chk("a5_dout", lnk.data_out, 32'hA5A5_3C01);

    // Back-to-back with startBit held high.
    pc = pulse_count;
    send(32'h1234_5678, 1'b1);
    k1 = last_k;
    lnk.data_in = 32'h9ABC_DEF0;
    g = 0;
    while (last_k == k1 && g < 400) begin
      @(posedge clk); #2;
      g++;
    end
    lnk.startBit = 1'b0;
    chk("b2b_gap", W'(last_k - k1), W'(FRAME + 1));
    wait_idle();
    chk("b2b_dout", lnk.data_out, 32'h9ABC_DEF0);
    chk("b2b_pulses", W'(pulse_count - pc), 2);

    // One-cycle glitch, then a frame with a low stop bit.
    pc = pulse_count;
    @(posedge clk); #2 lnk.ext_rx = 1'b0;
    @(posedge clk); #2 lnk.ext_rx = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    junk = $urandom;
    drive_line_bit(START_LVL);
    for (int i = 0; i < W; i++) drive_line_bit(junk[i]);
    drive_line_bit(1'b0);
    lnk.ext_rx = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    chk("bad_frame_dout", lnk.data_out, 32'h9ABC_DEF0);
    chk("bad_frame_pulses", W'(pulse_count - pc), 0);

    // Reset in the middle of the data bits.
    send($urandom, 1'b0);
    repeat (40) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_tx", lnk.tx, 1);
    chk("midrst_busy", lnk.busy, 0);
    chk("midrst_ready", lnk.dataReady, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("after_rst_dout", lnk.data_out, 0);
    send(32'hC0DE_1234, 1'b0);
    wait_idle();
    chk("after_rst_frame", lnk.data_out, 32'hC0DE_1234);

    // Randomised traffic, mixing back-to-back requests and idle gaps.
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      send(w, 1'b0);
      if ($urandom_range(0, 3) == 0) wait_idle();
      else repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_idle();
    chk("final_dout", lnk.data_out, w);
    chk("queue_drained", W'(pend.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_word_link.md
# uart_word_link

Asynchronous serial link that moves one 32-bit word per frame over a single wire. It consists of a `transmitter` that serialises a parallel word and a `receiver` that recovers it and flags completion. The pair is used for on-chip loopback: `tx` drives `rx` directly, both on the same clock. The two halves are separate modules sharing one parameter set and one frame format.

## Interface
Parameters (identical in both halves):
- `DATA_W`, 32, payload bits per frame.
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; even, ≥2.

Reset and clocking: one clock; reset is asynchronous and active-low, port name `reset`; clock port name `clk`.

`transmitter` ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `startBit` in 1: level request to send `data_in`.
- `data_in` in DATA_W: word to send; sampled at acceptance.
- `busy` out 1: high while a frame is in flight.
- `tx` out 1: serial line, idle high.

`receiver` ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line.
- `data_out` out DATA_W: last correctly received word.
- `dataReady` out 1: one-cycle pulse when a valid word lands.

## Operation
- Frame format: start bit 0, DATA_W data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT cycles, so a frame is (DATA_W+2)·CLKS_PER_BIT cycles. The line idles at 1.
- Transmitter FSM, states IDLE → START → DATA → STOP → IDLE:
  - Acceptance: rising edge with `reset`=1, state IDLE and `startBit`=1. On that edge it latches `data_in` into a shift register and sets `busy`=1.
  - `startBit` is ignored while busy. `data_in` may change freely after acceptance.
  - At the end of STOP it returns to IDLE and clears `busy` on the same edge.
  - If `startBit` is still high at that edge, it does not start again until the next edge (one idle cycle minimum).
- Receiver FSM, states IDLE → START → DATA → STOP → IDLE:
  - `rx` passes through a 2-flop synchroniser.
  - IDLE leaves on a synchronised 0.
  - START re-checks the line at mid-bit (CLKS_PER_BIT/2). If the line is 1 there, the 0 was a glitch and the FSM returns to IDLE with no output.
  - DATA samples each bit at mid-bit and shifts it in LSB first.
  - STOP samples at mid-bit:
    - 1: load `data_out` and pulse `dataReady` for exactly one cycle.
    - 0 (framing error): drop the word; `data_out` is unchanged and there is no pulse.
  - In both cases it returns to IDLE immediately, ready for a back-to-back start bit.
- Reset values: `tx`=1, `busy`=0, `data_out`=0, `dataReady`=0, both FSMs in IDLE.
- Reset asserted mid-frame aborts both sides at once. The partial word is discarded and no `dataReady` is produced.

## Timing
- Acceptance edge = cycle k. The start bit is on `tx` from k+1 (registered output).
- `busy` is high during cycles k+1 … k+(DATA_W+2)·CLKS_PER_BIT and low after that.
- In loopback, `dataReady` pulses exactly once, at most (DATA_W+1.5)·CLKS_PER_BIT+4 cycles after k. With the defaults that is ≤ 138 cycles.
- `data_out` is stable from the `dataReady` cycle until the next valid frame.

## Structure
- Shared package `uart_word_pkg` holds:
  - defaults DATA_W and CLKS_PER_BIT;
  - the state enum {IDLE, START, DATA, STOP};
  - frame constants START_LVL=0 and STOP_LVL=1.
- Two modules, `transmitter` and `receiver`.
- One natural sub-module, `bit_timer`: a counter that marks mid-bit and end-of-bit, instantiated in both halves.
- Wrapper `uart_word_link` connects `tx` to `rx` for loopback.

## Test plan
- Send 0xFFFFFFFF in loopback → one `dataReady` pulse, `data_out`=0xFFFFFFFF, `busy` drops.
- Send 0x00000000 → `data_out`=0x00000000. Checks the start bit is distinguishable from data.
- Send 0xA5A53C01 → `tx` bit 1 (first data bit) is 1 and bit 32 is 1; `data_out`=0xA5A53C01.
- Send 0x12345678 then 0x9ABCDEF0 with `startBit` held high → two pulses, values in order, one idle cycle between frames.
- Drive `rx` with a 1-cycle 0 glitch, then a frame whose stop bit is 0 → no `dataReady`; `data_out` keeps its previous value.
- Assert `reset` mid-data → `tx`=1, `busy`=0, `dataReady`=0 immediately; the next full frame is received correctly.
